// File: rtl/rtype_exec_pipe.sv
// Two-stage R-type execute pipe: register file read into EX, ALU + write-back/output registers at WB.
// Optional macro RTYPE_FWD_EN forwards the EX result to dependent issues instead of stalling one cycle.
module rtype_exec_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter int OPC_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] rd,
  input  logic [OPC_W-1:0]  opcode,
  input  logic              ext_we,
  input  logic [REG_AW-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_data,
  output logic              ext_ack,
  output logic              out_valid,
  output logic [DATA_W-1:0] out,
  output logic              cout,
  output logic              ovf,
  output logic              illegal,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);
  localparam int NREG = 2**REG_AW;
  localparam int SHW  = $clog2(DATA_W);
  localparam int MSB  = DATA_W-1;

  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_XOR  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_NOR  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_SLT  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_SLTU = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_SLL  = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_SRL  = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_SRA  = OPC_W'(10);

  logic [DATA_W-1:0] r_regs [NREG];

  logic              r_ex_valid;
  logic [REG_AW-1:0] r_ex_rd;
  logic [OPC_W-1:0]  r_ex_opc;
  logic [DATA_W-1:0] r_ex_a;
  logic [DATA_W-1:0] r_ex_b;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out;
  logic              r_cout;
  logic              r_ovf;
  logic              r_ill;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic              r_ext_ack;

  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_dif;
  logic [SHW-1:0]    w_shamt;
  logic [DATA_W-1:0] w_res;
  logic              w_cout;
  logic              w_ovf;
  logic              w_ill;
  logic              w_ex_wr;
  logic              w_hit_a;
  logic              w_hit_b;
  logic              w_stall;
  logic [DATA_W-1:0] w_opa;
  logic [DATA_W-1:0] w_opb;
  logic              w_accept;
  logic              w_ext_commit;

  // SUB as A + ~B + 1 so the carry out is the no-borrow flag.
  assign w_sum   = {1'b0, r_ex_a} + {1'b0, r_ex_b};
  assign w_dif   = {1'b0, r_ex_a} + {1'b0, ~r_ex_b} + (DATA_W+1)'(1);
  assign w_shamt = r_ex_b[SHW-1:0];

  always_comb begin
    w_res  = '0;
    w_cout = 1'b0;
    w_ovf  = 1'b0;
    w_ill  = 1'b0;
    case (r_ex_opc)
      OP_ADD: begin
        w_res  = w_sum[MSB:0];
        w_cout = w_sum[DATA_W];
        w_ovf  = (r_ex_a[MSB] == r_ex_b[MSB]) && (w_sum[MSB] != r_ex_a[MSB]);
      end
      OP_SUB: begin
        w_res  = w_dif[MSB:0];
        w_cout = w_dif[DATA_W];
        w_ovf  = (r_ex_a[MSB] != r_ex_b[MSB]) && (w_dif[MSB] != r_ex_a[MSB]);
      end
      OP_AND:  w_res = r_ex_a & r_ex_b;
      OP_OR:   w_res = r_ex_a | r_ex_b;
      OP_XOR:  w_res = r_ex_a ^ r_ex_b;
      OP_NOR:  w_res = ~(r_ex_a | r_ex_b);
      OP_SLT:  w_res = {{(DATA_W-1){1'b0}}, $signed(r_ex_a) < $signed(r_ex_b)};
      OP_SLTU: w_res = {{(DATA_W-1){1'b0}}, r_ex_a < r_ex_b};
      OP_SLL:  w_res = r_ex_a << w_shamt;
      OP_SRL:  w_res = r_ex_a >> w_shamt;
      OP_SRA:  w_res = $signed(r_ex_a) >>> w_shamt;
      default: w_ill = 1'b1;
    endcase
  end

  // Only a legal EX op writes back, so only it can create a dependency.
  assign w_ex_wr = r_ex_valid && !w_ill;
  assign w_hit_a = w_ex_wr && (rs == r_ex_rd);
  assign w_hit_b = w_ex_wr && (rt == r_ex_rd);

`ifdef RTYPE_FWD_EN
  assign w_opa   = w_hit_a ? w_res : r_regs[rs];
  assign w_opb   = w_hit_b ? w_res : r_regs[rt];
  assign w_stall = 1'b0;
`else
  assign w_opa   = r_regs[rs];
  assign w_opb   = r_regs[rt];
  assign w_stall = w_hit_a || w_hit_b;
`endif

  assign in_ready = !reset && !ext_we && !w_stall;
  assign w_accept = in_valid && in_ready;
  // Load waits for an empty EX so it never collides with write-back; r_ext_ack blocks a repeat while ext_we is still held.
  assign w_ext_commit = ext_we && !r_ex_valid && !r_ext_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (r_ex_valid && !w_ill) begin
      r_regs[r_ex_rd] <= w_res;
    end else if (w_ext_commit) begin
      r_regs[ext_addr] <= ext_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_valid  <= 1'b0;
      r_ex_rd     <= '0;
      r_ex_opc    <= '0;
      r_ex_a      <= '0;
      r_ex_b      <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_ill       <= 1'b0;
      r_rd1       <= '0;
      r_rd2       <= '0;
      r_ext_ack   <= 1'b0;
    end else begin
      r_ex_valid  <= w_accept;
      r_out_valid <= r_ex_valid;
      r_ext_ack   <= w_ext_commit;
      if (w_accept) begin
        r_ex_rd  <= rd;
        r_ex_opc <= opcode;
        r_ex_a   <= w_opa;
        r_ex_b   <= w_opb;
      end
      if (r_ex_valid) begin
        r_out  <= w_res;
        r_cout <= w_cout;
        r_ovf  <= w_ovf;
        r_ill  <= w_ill;
        r_rd1  <= r_ex_a;
        r_rd2  <= r_ex_b;
      end
    end
  end

  assign ext_ack   = r_ext_ack;
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign illegal   = r_ill;
  assign rd1       = r_rd1;
  assign rd2       = r_rd2;
endmodule

// File: tb/tb_rtype_exec_pipe.sv
// Scoreboard bench for rtype_exec_pipe: driver pushes hand-computed results on accept, monitor pops on out_valid.
module tb_rtype_exec_pipe;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int OW = 5;
`ifdef RTYPE_FWD_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 2;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] rs, rt, rd;
  logic [OW-1:0] opcode;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_data;
  logic          ext_ack;
  logic          out_valid;
  logic [DW-1:0] out;
  logic          cout, ovf, illegal;
  logic [DW-1:0] rd1, rd2;

  rtype_exec_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs(rs), .rt(rt), .rd(rd), .opcode(opcode),
    .ext_we(ext_we), .ext_addr(ext_addr), .ext_data(ext_data), .ext_ack(ext_ack),
    .out_valid(out_valid), .out(out), .cout(cout), .ovf(ovf), .illegal(illegal),
    .rd1(rd1), .rd2(rd2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] res;
    logic          c, v, ill;
    logic [DW-1:0] a, b;
    int            cyc;
    string         nm;
  } exp_t;

  exp_t sbq[$];
  exp_t m_e;

  always @(negedge clk) begin
    if (out_valid) begin
      if (sbq.size() == 0) chk("unexpected_out_valid", 64'(out_valid), 64'd0);
      else begin
        m_e = sbq.pop_front();
        chk({m_e.nm, "_out"}, 64'(out), 64'(m_e.res));
        chk({m_e.nm, "_cout"}, 64'(cout), 64'(m_e.c));
        chk({m_e.nm, "_ovf"}, 64'(ovf), 64'(m_e.v));
        chk({m_e.nm, "_illegal"}, 64'(illegal), 64'(m_e.ill));
        chk({m_e.nm, "_rd1"}, 64'(rd1), 64'(m_e.a));
        chk({m_e.nm, "_rd2"}, 64'(rd2), 64'(m_e.b));
        chk({m_e.nm, "_latency"}, 64'(cyc), 64'(m_e.cyc + 1));
      end
    end
  end

  // Called right after a negedge; returns at the negedge following the accepting edge.
  task automatic issue(input string nm, input logic [AW-1:0] s, t, d, input logic [OW-1:0] op,
                       input logic [DW-1:0] res, input logic c, v, ill,
                       input logic [DW-1:0] a, b, input bit push, output int acc);
    bit rdy;
    int n;
    exp_t e;
    n = 0;
    rs = s; rt = t; rd = d; opcode = op; in_valid = 1'b1;
    do begin
      #1 rdy = in_ready;
      @(negedge clk);
      n++;
    end while (!rdy && n < 20);
    in_valid = 1'b0;
    acc = cyc;
    if (!rdy) chk({nm, "_accept_timeout"}, 64'd0, 64'd1);
    else if (push) begin
      e.res = res; e.c = c; e.v = v; e.ill = ill; e.a = a; e.b = b; e.cyc = cyc; e.nm = nm;
      sbq.push_back(e);
    end
  endtask

  task automatic iss(input string nm, input logic [AW-1:0] s, t, d, input logic [OW-1:0] op,
                     input logic [DW-1:0] res, input logic c, v, ill, input logic [DW-1:0] a, b);
    int acc;
    issue(nm, s, t, d, op, res, c, v, ill, a, b, 1'b1, acc);
  endtask

  task automatic load(input logic [AW-1:0] ad, input logic [DW-1:0] dat);
    int n;
    n = 0;
    ext_we = 1'b1; ext_addr = ad; ext_data = dat;
    do begin
      @(negedge clk);
      n++;
    end while (!ext_ack && n < 20);
    chk("ext_ack_seen", 64'(ext_ack), 64'd1);
    ext_we = 1'b0;
    @(negedge clk);
    chk("ext_ack_single_pulse", 64'(ext_ack), 64'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drain", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    int a1, a2;
    reset = 1'b1; in_valid = 1'b0; rs = '0; rt = '0; rd = '0; opcode = '0;
    ext_we = 1'b0; ext_addr = '0; ext_data = '0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_ext_ack", 64'(ext_ack), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    @(negedge clk);

    // basic add, rs==rt read-back, illegal op leaves destination alone
    load(4'd1, 32'd5);
    load(4'd2, 32'd3);
    iss("add_5_3", 1, 2, 3, 0, 32'd8, 0, 0, 0, 32'd5, 32'd3);
    iss("rdback_r3", 3, 3, 6, 2, 32'd8, 0, 0, 0, 32'd8, 32'd8);
    iss("illegal31", 1, 2, 3, 31, 32'd0, 0, 0, 1, 32'd5, 32'd3);
    iss("r3_kept", 3, 3, 6, 2, 32'd8, 0, 0, 0, 32'd8, 32'd8);

    // dependent pair: issue spacing reveals stall vs forward
    issue("dep_add", 1, 2, 3, 0, 32'd8, 0, 0, 0, 32'd5, 32'd3, 1'b1, a1);
    issue("dep_sub", 3, 1, 4, 1, 32'd3, 1, 0, 0, 32'd8, 32'd5, 1'b1, a2);
    chk("dep_issue_gap", 64'(a2 - a1), 64'(GAP));
    drain();

    load(4'd1, 32'h7FFF_FFFF);
    load(4'd2, 32'd1);
    iss("add_ovf", 1, 2, 3, 0, 32'h8000_0000, 0, 1, 0, 32'h7FFF_FFFF, 32'd1);
    load(4'd5, 32'd0);
    load(4'd6, 32'd1);
    iss("sub_0_1", 5, 6, 7, 1, 32'hFFFF_FFFF, 0, 0, 0, 32'd0, 32'd1);
    load(4'd1, 32'h8000_0000);
    load(4'd2, 32'd4);
    iss("sra_neg", 1, 2, 3, 10, 32'hF800_0000, 0, 0, 0, 32'h8000_0000, 32'd4);
    load(4'd2, 32'd1);
    iss("sub_ovf", 1, 2, 3, 1, 32'h7FFF_FFFF, 1, 1, 0, 32'h8000_0000, 32'd1);
    load(4'd1, 32'hFFFF_FFFF);
    iss("slt_m1_1", 1, 2, 3, 6, 32'd1, 0, 0, 0, 32'hFFFF_FFFF, 32'd1);
    iss("sltu_m1_1", 1, 2, 4, 7, 32'd0, 0, 0, 0, 32'hFFFF_FFFF, 32'd1);
    iss("add_carry", 1, 2, 5, 0, 32'd0, 1, 0, 0, 32'hFFFF_FFFF, 32'd1);
    iss("sub_noborrow", 1, 2, 6, 1, 32'hFFFF_FFFE, 1, 0, 0, 32'hFFFF_FFFF, 32'd1);

    // logic ops and shifts; SRL reads the SLL result straight away
    load(4'd1, 32'h1234_5678);
    load(4'd2, 32'h0000_FF04);
    iss("and", 1, 2, 8, 2, 32'h0000_5600, 0, 0, 0, 32'h1234_5678, 32'h0000_FF04);
    iss("or", 1, 2, 9, 3, 32'h1234_FF7C, 0, 0, 0, 32'h1234_5678, 32'h0000_FF04);
    iss("xor", 1, 2, 10, 4, 32'h1234_A97C, 0, 0, 0, 32'h1234_5678, 32'h0000_FF04);
    iss("nor", 1, 2, 11, 5, 32'hEDCB_0083, 0, 0, 0, 32'h1234_5678, 32'h0000_FF04);
    iss("sll", 1, 2, 9, 8, 32'h2345_6780, 0, 0, 0, 32'h1234_5678, 32'h0000_FF04);
    iss("srl_dep", 9, 2, 10, 9, 32'h0234_5678, 0, 0, 0, 32'h2345_6780, 32'h0000_FF04);
    iss("sra_pos", 1, 2, 12, 10, 32'h0123_4567, 0, 0, 0, 32'h1234_5678, 32'h0000_FF04);
    drain();

    // reset while EX holds an ADD: nothing may come out, every register cleared
    issue("rst_victim", 1, 2, 3, 0, 32'd0, 0, 0, 0, 32'd0, 32'd0, 1'b0, a1);
    reset = 1'b1;
    #1;
    chk("in_ready_in_reset", 64'(in_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("in_ready_post_reset", 64'(in_ready), 64'd1);
    chk("no_out_after_reset", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("no_out_victim", 64'(out_valid), 64'd0);
    for (int i = 0; i < 16; i++)
      iss($sformatf("zero_r%0d", i), AW'(i), AW'(i), AW'(i), 3, 32'd0, 0, 0, 0, 32'd0, 32'd0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rtype_exec_pipe.md
Name: rtype_exec_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle R-type datapath: register file, ALU and write-back in a 2-stage pipeline with a valid/ready issue handshake.
- Adds an external register-load port, hazard handling, overflow/illegal-op flags and registered outputs.
- Sits between instruction decode (rs/rt/rd/opcode) and any downstream result consumer or trace monitor.

Parameters:
- DATA_W, 32, datapath width in bits (≥8, power of 2).
- REG_AW, 4, register address width; register file holds 2**REG_AW entries.
- OPC_W, 5, opcode width (≥4).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  instruction accepted when in_valid & in_ready at a rising edge.
- rs  in  REG_AW  source register A.
- rt  in  REG_AW  source register B.
- rd  in  REG_AW  destination register.
- opcode  in  OPC_W  ALU operation.
- ext_we  in  1  external register-load request; held until ext_ack.
- ext_addr  in  REG_AW  load address.
- ext_data  in  DATA_W  load data.
- ext_ack  out  1  one-cycle pulse when the external load commits.
- out_valid  out  1  result valid (one cycle per instruction).
- out  out  DATA_W  ALU result.
- cout  out  1  carry out (ADD/SUB only, else 0).
- ovf  out  1  signed overflow (ADD/SUB only, else 0).
- illegal  out  1  opcode undefined.
- rd1  out  DATA_W  operand A used by this result.
- rd2  out  DATA_W  operand B used by this result.

Behaviour:
- Reset: all registers, EX stage and outputs cleared to 0; in_ready=0 during reset, 1 in the first cycle after reset unless a stall applies.
- Stage EX: on acceptance, operands are read from the register file and latched with rd/opcode; ex_valid=1.
- Stage WB: in the cycle ex_valid=1, the ALU evaluates. At the next edge:
  - result is written to reg[rd] unless illegal;
  - out/cout/ovf/illegal/rd1/rd2 are registered and out_valid=1 for one cycle.
- Latency: 2 edges from acceptance to out_valid. Throughput: 1 instruction/cycle.
- No output backpressure.
- Opcodes:
  - 0 ADD, 1 SUB (cout = no-borrow), 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed), 7 SLTU: result 1 or 0, zero-extended.
  - 8 SLL, 9 SRL, 10 SRA: shift amount = rd2[log2(DATA_W)-1:0].
  - All other opcodes: out=0, illegal=1, no register write.
- Arithmetic is modulo 2**DATA_W. ovf is set when the operand signs match (ADD) or differ (SUB) and the result sign differs from A.
- Hazard: an instruction whose rs or rt equals the EX-stage rd (ex_valid, legal op) needs the EX result; handling is per the Optional Feature.
- rs==rt is legal; both operands receive the same value.
- External load:
  - While ext_we=1, in_ready=0 (no issue).
  - The load commits at the first edge with ex_valid=0; ext_ack pulses in the following cycle. The requester drops ext_we after ext_ack.
  - A write-back and an external load never share an edge.
- in_valid with in_ready=0: the instruction is held by the source, not dropped.
- Reset mid-operation: the in-flight EX instruction is discarded (no write, no out_valid); all registers are zeroed.
- All registers, including reg 0, are writable.

Optional Feature:
- Macro: RTYPE_FWD_EN.
- Defined: EX result is forwarded combinationally into the operand latch for dependent instructions; in_ready is never dropped for hazards, and back-to-back dependent instructions issue every cycle.
- Undefined: in_ready=0 for one cycle on a hazard; the instruction issues the next cycle and reads the written-back value.
- Results are identical in both builds; only timing differs.

Test Plan:
- Load reg1=5, reg2=3 via ext port; issue ADD r3=r1+r2 -> ext_ack once per load; out_valid 2 cycles after accept, out=8, cout=0, ovf=0, reg3=8.
- reg1=0x7FFFFFFF, reg2=1, ADD -> out=0x80000000, ovf=1, cout=0. SUB 0-1 -> out=0xFFFFFFFF, cout=0.
- Dependent pair: ADD r3=r1+r2 then SUB r4=r3-r1 (reg1=5, reg2=3) -> r4 result=3.
  - With RTYPE_FWD_EN: accepted on consecutive cycles.
  - Without RTYPE_FWD_EN: exactly one in_ready=0 cycle.
- SRA with reg1=0x80000000, reg2=4 -> 0xF8000000. SLT -1<1 -> 1. SLTU -1<1 -> 0.
- opcode=31 -> illegal=1, out=0, destination register unchanged.
- reset asserted while EX holds an ADD -> no out_valid, all registers 0, in_ready=1 the cycle after reset deasserts.
